// File: rtl/data_unpacker_if.sv
// Stream bundle for data_unpacker: packed-vector input side and
// unpacked-chunk output side, each with ready/valid flow control.
//   valid_in / count_in / vector_in / ready_out : packed input stream
//   vector_out / length_out / valid_out / ready_in : chunk output stream
// slave modport is the unpacker's view; master is the environment's view.
interface data_unpacker_if #(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned CW = $clog2(N + 1);

  logic                         valid_in;
  logic [CW-1:0]                count_in;
  logic [N-1:0][DATA_WIDTH-1:0] vector_in;
  logic                         ready_out;
  logic [N-1:0][DATA_WIDTH-1:0] vector_out;
  logic [CW-1:0]                length_out;
  logic                         valid_out;
  logic                         ready_in;

  modport slave (
    input  valid_in, count_in, vector_in, ready_in,
    output ready_out, vector_out, length_out, valid_out
  );

  modport master (
    output valid_in, count_in, vector_in, ready_in,
    input  ready_out, vector_out, length_out, valid_out
  );
endinterface

// File: rtl/data_unpacker.sv
// data_unpacker: splits N-wide packed vectors back into their original
// L-element chunks (L = N, M or 1 by mode), one chunk per output beat.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   tracing             1 = run, 0 = config bytes may be written
//   configId/configData config bus; first byte of a burst to our id sets mode
//   bus (slave)         packed input stream and chunk output stream
module data_unpacker #(
  parameter int unsigned N                  = 8,
  parameter int unsigned M                  = 2,
  parameter int unsigned DATA_WIDTH         = 32,
  parameter logic [7:0]  PERSONAL_CONFIG_ID = 8'd0,
  parameter logic [7:0]  INITIAL_MODE       = 8'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tracing,
  input  logic [7:0]  configId,
  input  logic [7:0]  configData,
  data_unpacker_if.slave bus
);
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned IW = $clog2(N);

  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;
  typedef enum logic {IDLE, EMIT} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mode_q;
  logic          cfg_seen_q;
  vec_t          buf_q, buf_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] ptr_q, ptr_d;
  vec_t          vout_q, vout_d;
  logic [CW-1:0] lout_q, lout_d;
  logic          valid_q, valid_d;
  logic          ready_q, ready_d;

  logic [CW-1:0] count_eff_c, gap_c, len_dec_c, start_c;
  logic          discard_c;
  vec_t          chunk_c;
  logic [SW-1:0] lane_sum;

  // Config: only the first byte of a burst addressed to us lands in mode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q     <= INITIAL_MODE;
      cfg_seen_q <= 1'b0;
    end else if (configId != PERSONAL_CONFIG_ID) begin
      cfg_seen_q <= 1'b0;
    end else if (!tracing && !cfg_seen_q) begin
      mode_q     <= configData;
      cfg_seen_q <= 1'b1;
    end
  end

  // Mode decode and start lane; valid data is right-aligned in the vector.
  always_comb begin
    count_eff_c = (bus.count_in == '0 || bus.count_in > CW'(N)) ? CW'(N) : bus.count_in;
    gap_c       = CW'(N) - count_eff_c;
    len_dec_c   = CW'(N);
    start_c     = '0;
    discard_c   = 1'b0;
    case (mode_q)
      8'd0: begin
        len_dec_c = CW'(N);
        start_c   = '0;
      end
      8'd1: begin
        len_dec_c = CW'(M);
        start_c   = CW'((gap_c / CW'(M)) * CW'(M));
      end
      8'd2: begin
        len_dec_c = CW'(1);
        start_c   = gap_c;
      end
      default: discard_c = 1'b1;
    endcase
  end

  // Chunk at ptr moved down to lanes [L-1:0], upper lanes zero.
  always_comb begin
    chunk_c  = '0;
    lane_sum = '0;
    for (int unsigned i = 0; i < N; i++) begin
      lane_sum = SW'(ptr_q) + SW'(i);
      if (CW'(i) < len_q && lane_sum < SW'(N)) begin
        chunk_c[IW'(i)] = buf_q[IW'(lane_sum)];
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      len_q   <= '0;
      ptr_q   <= '0;
      vout_q  <= '0;
      lout_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      vout_q  <= vout_d;
      lout_q  <= lout_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  // Next-state: accept in IDLE, emit one chunk per output slot in EMIT.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    vout_d  = vout_q;
    lout_d  = lout_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        // A final beat may still be pending here; retire it when taken.
        if (valid_q && bus.ready_in) valid_d = 1'b0;
        if (ready_q && bus.valid_in && tracing) begin
          buf_d = bus.vector_in;
          len_d = len_dec_c;
          ptr_d = start_c;
          if (!discard_c) state_d = EMIT;
        end
      end
      EMIT: begin
        if (!valid_q || bus.ready_in) begin
          vout_d  = chunk_c;
          lout_d  = len_q;
          valid_d = 1'b1;
          ptr_d   = ptr_q + len_q;
          if (ptr_q + len_q == CW'(N)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  assign bus.ready_out  = ready_q;
  assign bus.vector_out = vout_q;
  assign bus.length_out = lout_q;
  assign bus.valid_out  = valid_q;
endmodule

// File: tb/tb_data_unpacker.sv
// Bench for data_unpacker: directed scenarios with literal expectations,
// then randomized traffic checked beat-by-beat against a queue model.
module tb_data_unpacker;
  localparam int N  = 8;
  localparam int M  = 2;
  localparam int DW = 32;
  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(N);
  localparam int VW = N * DW;
  localparam logic [7:0] CFG_ID    = 8'd0;
  localparam logic [7:0] INIT_MODE = 8'd0;
  localparam logic [7:0] OTHER_ID  = 8'h5A;

  typedef logic [N-1:0][DW-1:0] vec_t;
  typedef struct {
    vec_t v;
    int   len;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       tracing;
  logic [7:0] configId;
  logic [7:0] configData;

  data_unpacker_if #(.N(N), .DATA_WIDTH(DW)) bus ();

  data_unpacker #(
    .N(N), .M(M), .DATA_WIDTH(DW),
    .PERSONAL_CONFIG_ID(CFG_ID), .INITIAL_MODE(INIT_MODE)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .tracing(tracing),
    .configId(configId),
    .configData(configData),
    .bus(bus)
  );

  always #5 clk = ~clk;

  beat_t         exp_q[$];
  beat_t         got_q[$];
  int            model_mode;
  int            total;
  int            bad;
  bit            hold_prev;
  vec_t          prev_v;
  logic [CW-1:0] prev_l;

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: cut the right-aligned valid elements into L-sized chunks.
  task automatic model_accept(input vec_t v, input int cnt);
    int    c;
    int    l;
    int    s;
    beat_t b;
    if (model_mode >= 3) return;
    c = (cnt == 0 || cnt > N) ? N : cnt;
    l = (model_mode == 0) ? N : (model_mode == 1) ? M : 1;
    s = ((N - c) / l) * l;
    for (int p = s; p < N; p += l) begin
      b.v   = '0;
      b.len = l;
      for (int i = 0; i < l; i++) b.v[IW'(i)] = v[IW'(p + i)];
      exp_q.push_back(b);
    end
  endtask

  // Per-cycle compare, sampled on the falling edge.
  task automatic monitor_cycle();
    beat_t e;
    beat_t g;
    if (!reset_n) begin
      exp_q.delete();
      hold_prev = 1'b0;
      return;
    end
    if (hold_prev) begin
      chk("hold_valid", VW'(bus.valid_out), VW'(1));
      chk("hold_vector", VW'(bus.vector_out), VW'(prev_v));
      chk("hold_length", VW'(bus.length_out), VW'(prev_l));
    end
    if (bus.valid_out && bus.ready_in) begin
      g.v   = bus.vector_out;
      g.len = int'(bus.length_out);
      got_q.push_back(g);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_beat: got beat %0h want none", bus.vector_out);
      end else begin
        e = exp_q.pop_front();
        chk("beat_vector", VW'(bus.vector_out), VW'(e.v));
        chk("beat_length", VW'(bus.length_out), VW'(e.len));
      end
    end
    hold_prev = bus.valid_out && !bus.ready_in;
    prev_v    = bus.vector_out;
    prev_l    = bus.length_out;
    if (bus.valid_in && bus.ready_out && tracing) model_accept(bus.vector_in, int'(bus.count_in));
  endtask

  task automatic step();
    @(negedge clk);
    monitor_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic config_burst(input logic [7:0] b0, input logic [7:0] b1);
    bus.valid_in = 1'b0;
    tracing      = 1'b0;
    configId     = CFG_ID;
    configData   = b0;
    step();
    model_mode   = int'(b0);
    configData   = b1;
    step();
    configId     = OTHER_ID;
    step();
    tracing      = 1'b1;
  endtask

  task automatic send(input vec_t v, input logic [CW-1:0] cnt);
    int guard;
    guard = 0;
    while (!bus.ready_out && guard < 100) begin
      step();
      guard++;
    end
    chk("send_ready", VW'(bus.ready_out), VW'(1));
    bus.vector_in = v;
    bus.count_in  = cnt;
    bus.valid_in  = 1'b1;
    step();
    bus.valid_in  = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard        = 0;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    while ((exp_q.size() != 0 || bus.valid_out || !bus.ready_out) && guard < 200) begin
      step();
      guard++;
    end
    chk("drain_idle", VW'({exp_q.size() == 0, bus.valid_out, bus.ready_out}), VW'(3'b101));
  endtask

  task automatic chk_got(input string nm, input int idx, input vec_t ev, input int el);
    if (idx < got_q.size()) begin
      chk(nm, VW'(got_q[idx].v), VW'(ev));
      chk({nm, "_len"}, VW'(got_q[idx].len), VW'(el));
    end else begin
      total++;
      bad++;
      $display("FAIL %s: got %0d beats want more than %0d", nm, got_q.size(), idx);
    end
  endtask

  initial begin
    vec_t ramp;
    vec_t ev;
    vec_t v4;
    int   base;

    total         = 0;
    bad           = 0;
    hold_prev     = 1'b0;
    model_mode    = int'(INIT_MODE);
    tracing       = 1'b1;
    configId      = OTHER_ID;
    configData    = 8'd0;
    bus.valid_in  = 1'b0;
    bus.count_in  = '0;
    bus.vector_in = '0;
    bus.ready_in  = 1'b1;
    for (int i = 0; i < N; i++) ramp[IW'(i)] = DW'(i + 1);

    // Reset values.
    #1 reset_n = 1'b0;
    #1;
    chk("rst_valid", VW'(bus.valid_out), VW'(0));
    chk("rst_vector", VW'(bus.vector_out), VW'(0));
    chk("rst_length", VW'(bus.length_out), VW'(0));
    chk("rst_ready", VW'(bus.ready_out), VW'(0));
    step();
    step();
    reset_n = 1'b1;
    chk("rst_ready_hold", VW'(bus.ready_out), VW'(0));
    step();
    chk("rst_ready_rise", VW'(bus.ready_out), VW'(1));

    // Mode 2 via config burst (second byte ignored): eight single-lane beats.
    config_burst(8'd2, 8'd5);
    base = got_q.size();
    send(ramp, CW'(0));
    for (int k = 0; k < 8; k++) begin
      chk("m2_ready_low", VW'(bus.ready_out), VW'(0));
      step();
    end
    chk("m2_ready_high", VW'(bus.ready_out), VW'(1));
    drain();
    chk("m2_count", VW'(got_q.size() - base), VW'(8));
    for (int k = 0; k < 8; k++) begin
      ev = '0;
      ev[0] = DW'(k + 1);
      chk_got("m2_beat", base + k, ev, 1);
    end

    // Mode 1: four two-lane beats.
    config_burst(8'd1, 8'd0);
    base = got_q.size();
    send(ramp, CW'(0));
    drain();
    chk("m1_count", VW'(got_q.size() - base), VW'(4));
    for (int k = 0; k < 4; k++) begin
      ev = '0;
      ev[0] = DW'(2 * k + 1);
      ev[1] = DW'(2 * k + 2);
      chk_got("m1_beat", base + k, ev, 2);
    end

    // Mode 0: one full beat, one cycle after acceptance.
    config_burst(8'd0, 8'd7);
    send(ramp, CW'(0));
    chk("m0_not_yet", VW'(bus.valid_out), VW'(0));
    step();
    chk("m0_valid", VW'(bus.valid_out), VW'(1));
    chk("m0_vector", VW'(bus.vector_out), VW'(ramp));
    chk("m0_length", VW'(bus.length_out), VW'(8));
    drain();

    // Partial vector: three elements in the top lanes.
    config_burst(8'd2, 8'd2);
    for (int i = 0; i < 5; i++) v4[IW'(i)] = 32'hDEAD_0000 | DW'(i);
    v4[5] = 32'hA;
    v4[6] = 32'hB;
    v4[7] = 32'hC;
    base = got_q.size();
    send(v4, CW'(3));
    drain();
    chk("part_count", VW'(got_q.size() - base), VW'(3));
    for (int k = 0; k < 3; k++) begin
      ev = '0;
      ev[0] = DW'(32'hA + k);
      chk_got("part_beat", base + k, ev, 1);
    end

    // Backpressure: second beat held for three cycles.
    config_burst(8'd1, 8'd1);
    base = got_q.size();
    send(ramp, CW'(0));
    step();
    step();
    ev = '0;
    ev[0] = DW'(3);
    ev[1] = DW'(4);
    chk("bp_second", VW'(bus.vector_out), VW'(ev));
    bus.ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_valid", VW'(bus.valid_out), VW'(1));
      chk("bp_vector", VW'(bus.vector_out), VW'(ev));
    end
    bus.ready_in = 1'b1;
    drain();
    chk("bp_count", VW'(got_q.size() - base), VW'(4));
    for (int k = 0; k < 4; k++) begin
      ev = '0;
      ev[0] = DW'(2 * k + 1);
      ev[1] = DW'(2 * k + 2);
      chk_got("bp_beat", base + k, ev, 2);
    end

    // Reset in the middle of an emission.
    send(ramp, CW'(0));
    step();
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", VW'(bus.valid_out), VW'(0));
    chk("mid_rst_vector", VW'(bus.vector_out), VW'(0));
    chk("mid_rst_length", VW'(bus.length_out), VW'(0));
    chk("mid_rst_ready", VW'(bus.ready_out), VW'(0));
    step();
    step();
    model_mode = int'(INIT_MODE);
    reset_n = 1'b1;
    step();
    // Config bytes while tracing must not change the mode.
    configId   = CFG_ID;
    configData = 8'd2;
    step();
    step();
    configId   = OTHER_ID;
    base = got_q.size();
    send(ramp, CW'(0));
    drain();
    chk("post_rst_count", VW'(got_q.size() - base), VW'(1));
    chk_got("post_rst_beat", base, ramp, 8);

    // Randomized traffic, modes including discard, with mid-stream config.
    for (int b = 0; b < 12; b++) begin
      logic [7:0] m;
      m = (b % 5 == 4) ? 8'(3 + $urandom_range(0, 200)) : 8'($urandom_range(0, 2));
      config_burst(m, 8'($urandom));
      for (int c = 0; c < 150; c++) begin
        vec_t rv;
        for (int i = 0; i < N; i++) rv[IW'(i)] = DW'($urandom);
        bus.vector_in = rv;
        bus.count_in  = CW'($urandom_range(0, 15));
        bus.valid_in  = ($urandom_range(0, 3) != 0);
        bus.ready_in  = ($urandom_range(0, 3) != 0);
        tracing       = ($urandom_range(0, 15) != 0);
        step();
      end
      tracing = 1'b1;
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_unpacker.md
Name: data_unpacker

Overview:
Receive-side counterpart of the trace data packer. It takes N-wide packed vectors and re-emits the original sub-vectors, one per output beat. Each input holds N/L chunks of L elements, where L is N, M or 1. The block sits between the trace-buffer readout and downstream analysis logic, and provides ready/valid flow control on both sides.

Parameters:
N, 8, vector width in elements
M, 2, intermediate chunk size; N mod M must be 0
DATA_WIDTH, 32, element width in bits
PERSONAL_CONFIG_ID, 0, configId value addressing this block
INITIAL_MODE, 0, mode register value at reset

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
tracing  input  1  1 = run; 0 = config bytes may be written
configId  input  8  config target id
configData  input  8  config byte
valid_in  input  1  packed vector valid
count_in  input  $clog2(N+1)  valid elements in vector_in; 0 means N
vector_in  input  DATA_WIDTH x N  packed vector
ready_out  output  1  block can accept vector_in
vector_out  output  DATA_WIDTH x N  unpacked chunk in lanes [L-1:0], zeros elsewhere
length_out  output  $clog2(N+1)  L of current chunk
valid_out  output  1  vector_out valid
ready_in  input  1  downstream accepts vector_out

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, valid_out=0, vector_out all zero, length_out=0, ready_out=0.
  - mode=INITIAL_MODE, byte counter=0.
  - ready_out rises on the first clk edge after reset_n deasserts.
- Config path:
  - Active only while tracing=0 and configId==PERSONAL_CONFIG_ID.
  - Byte counter 0: configData is written to mode. Later bytes in the same burst are ignored.
  - configId != PERSONAL_CONFIG_ID clears the byte counter.
  - No config writes while tracing=1.
- Mode decode: 0 -> L=N; 1 -> L=M; 2 -> L=1; >=3 -> discard (inputs accepted, nothing emitted).
- Element ordering (matches packer fill order):
  - Valid elements occupy lanes N-C..N-1, where C = (count_in==0 || count_in>N) ? N : count_in.
  - The oldest chunk is at the lowest valid lanes.
  - Start lane S = N-C rounded down to a multiple of L.
  - Chunk k = vector_in[S+k*L +: L], k=0..(N-S)/L-1.
- States: IDLE, EMIT.
- IDLE:
  - ready_out=1.
  - On valid_in & tracing: latch vector_in into buffer; latch L; ptr=S.
  - Then go to EMIT, or stay in IDLE if mode>=3.
  - valid_in while tracing=0 is ignored.
- EMIT:
  - ready_out=0.
  - When valid_out==0 or ready_in==1, the output register loads:
    - vector_out[L-1:0] = buf[ptr +: L], other lanes 0
    - length_out=L, valid_out=1, ptr += L
  - If ptr+L==N at load, go to IDLE; ready_out=1 the next cycle.
  - If no new chunk loads and ready_in==1, valid_out drops to 0.
- Output rules:
  - While valid_out=1 and ready_in=0, vector_out and length_out hold stable.
  - First chunk appears 1 cycle after input acceptance.
  - Full-throughput input rate is one vector per N/L+1 cycles.
- Latching: L and S are latched at acceptance. A mode write or tracing drop mid-EMIT does not affect the in-flight vector; the vector completes.
- Final beat: the last beat may still be held (ready_in=0) when the block returns to IDLE. The next vector's first chunk loads only once that beat is taken.
- Widths: ptr is $clog2(N+1) bits; ptr never exceeds N.

Test Plan:
- mode=2, count_in=0, vector_in lanes 0..7 = 1..8, ready_in=1 -> 8 beats, vector_out[0]=1..8, length_out=1, other lanes 0; ready_out low 8 cycles, high on the 9th.
- mode=1 (M=2), same vector -> 4 beats with lanes[1:0] = (1,2),(3,4),(5,6),(7,8), length_out=2.
- mode=0 -> single beat equal to vector_in, length_out=8, valid 1 cycle after acceptance.
- mode=2, count_in=3, lanes 5..7 = 0xA,0xB,0xC -> exactly 3 beats: 0xA, 0xB, 0xC.
- mode=1, ready_in held 0 for 3 cycles after the 2nd beat -> beat 2 held stable (valid_out=1) 3 cycles; remaining beats follow with no loss or duplication.
- Config and reset:
  - tracing=0, configId=PERSONAL_CONFIG_ID, configData=2 then 5 -> mode=2 (the 5 is ignored).
  - reset_n pulsed low mid-EMIT -> valid_out=0 and vector_out zero immediately; mode returns to INITIAL_MODE.
